// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//   Decodes a PS/2 set-2 scan-code byte stream and tracks held/released
//   state for NUM_KEYS keys at once. The E0 (extended) and F0 (break)
//   prefixes are decoded, the 8-byte Pause sequence is skipped, and
//   keyboard ack/noise bytes seen while idle are discarded.
//
// Ports
//   CLOCK_50     in   system clock
//   resetn       in   synchronous active-low reset
//   scan_code    in   [7:0] byte from the keyboard core
//   scan_valid   in   one-cycle strobe; one byte is consumed per high cycle
//   key_down     out  [NUM_KEYS-1:0] level, bit i high while key i is held
//   key_pressed  out  [NUM_KEYS-1:0] one-cycle pulse on up->down of key i
//   key_released out  [NUM_KEYS-1:0] one-cycle pulse on down->up of key i
//   last_code    out  [7:0] code byte of the latest event, prefixes stripped
//   last_ext     out  latest event carried E0
//   last_break   out  latest event carried F0
//   event_valid  out  one-cycle pulse whenever last_* update
module ps2_key_tracker #(
    parameter int unsigned               NUM_KEYS  = 4,
    parameter logic [NUM_KEYS*8-1:0]     KEY_CODES = {8'h29, 8'h5A, 8'h6B, 8'h74},
    parameter logic [NUM_KEYS-1:0]       KEY_EXT   = 4'b0011
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic [7:0]          scan_code,
    input  logic                scan_valid,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_KEYS-1:0] key_pressed,
    output logic [NUM_KEYS-1:0] key_released,
    output logic [7:0]          last_code,
    output logic                last_ext,
    output logic                last_break,
    output logic                event_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK,
        S_SKIP
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          skip_q, skip_d;
    logic [NUM_KEYS-1:0] down_q, down_d;
    logic [NUM_KEYS-1:0] pressed_q, pressed_d;
    logic [NUM_KEYS-1:0] released_q, released_d;
    logic [7:0]          code_q, code_d;
    logic                ext_q, ext_d;
    logic                brk_q, brk_d;
    logic                ev_q, ev_d;

    logic                noise;

    // Ack/self-test/error bytes the keyboard may emit between events.
    always_comb begin
        unique case (scan_code)
            8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF: noise = 1'b1;
            default:                                         noise = 1'b0;
        endcase
    end

    // Byte parser: decides next state and whether this byte completes an event.
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        ev_d    = 1'b0;
        code_d  = code_q;
        ext_d   = ext_q;
        brk_d   = brk_q;

        if (scan_valid) begin
            if (state_q == S_SKIP) begin
                skip_d = (skip_q == 3'd0) ? 3'd0 : skip_q - 3'd1;
                if (skip_q <= 3'd1) begin
                    state_d = S_IDLE;
                end
            end else if (scan_code == 8'hE0) begin
                // E0 restarts parsing from any prefix state
                state_d = S_EXT;
            end else if (scan_code == 8'hE1) begin
                // Pause: E1 plus seven more bytes are swallowed
                state_d = S_SKIP;
                skip_d  = 3'd7;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (scan_code == 8'hF0) begin
                            state_d = S_BRK;
                        end else if (!noise) begin
                            ev_d   = 1'b1;
                            code_d = scan_code;
                            ext_d  = 1'b0;
                            brk_d  = 1'b0;
                        end
                    end
                    S_EXT: begin
                        if (scan_code == 8'hF0) begin
                            state_d = S_EXT_BRK;
                        end else begin
                            ev_d    = 1'b1;
                            code_d  = scan_code;
                            ext_d   = 1'b1;
                            brk_d   = 1'b0;
                            state_d = S_IDLE;
                        end
                    end
                    S_BRK: begin
                        ev_d    = 1'b1;
                        code_d  = scan_code;
                        ext_d   = 1'b0;
                        brk_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                    S_EXT_BRK: begin
                        ev_d    = 1'b1;
                        code_d  = scan_code;
                        ext_d   = 1'b1;
                        brk_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // Per-key tracking; every key matching the event acts on it.
    always_comb begin
        down_d     = down_q;
        pressed_d  = '0;
        released_d = '0;
        if (ev_d) begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                if (code_d == KEY_CODES[8*i +: 8] && ext_d == KEY_EXT[i]) begin
                    if (brk_d) begin
                        released_d[i] = down_q[i];
                        down_d[i]     = 1'b0;
                    end else begin
                        pressed_d[i]  = ~down_q[i];
                        down_d[i]     = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            skip_q     <= '0;
            down_q     <= '0;
            pressed_q  <= '0;
            released_q <= '0;
            code_q     <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            ev_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            down_q     <= down_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            code_q     <= code_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            ev_q       <= ev_d;
        end
    end

    assign key_down     = down_q;
    assign key_pressed  = pressed_q;
    assign key_released = released_q;
    assign last_code    = code_q;
    assign last_ext     = ext_q;
    assign last_break   = brk_q;
    assign event_valid  = ev_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
module tb_ps2_key_tracker;

    localparam int NK = 4;

    logic          CLOCK_50 = 1'b0;
    logic          resetn = 1'b0;
    logic [7:0]    scan_code = '0;
    logic          scan_valid = 1'b0;
    logic [NK-1:0] key_down, key_pressed, key_released;
    logic [7:0]    last_code;
    logic          last_ext, last_break, event_valid;

    always #10 CLOCK_50 = ~CLOCK_50;

    ps2_key_tracker #(
        .NUM_KEYS  (4),
        .KEY_CODES (32'h295A6B74),
        .KEY_EXT   (4'b0011)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .resetn       (resetn),
        .scan_code    (scan_code),
        .scan_valid   (scan_valid),
        .key_down     (key_down),
        .key_pressed  (key_pressed),
        .key_released (key_released),
        .last_code    (last_code),
        .last_ext     (last_ext),
        .last_break   (last_break),
        .event_valid  (event_valid)
    );

    // Reference model: prefix flags + countdown, keys as a table of (code, ext).
    logic [7:0] code_tab [NK] = '{8'h74, 8'h6B, 8'h5A, 8'h29};
    logic       ext_tab  [NK] = '{1'b1, 1'b1, 1'b0, 1'b0};

    logic [NK-1:0] m_down, m_pr, m_rel;
    logic [7:0]    m_code;
    logic          m_ext, m_brk, m_ev;
    logic          pend_ext, pend_brk;
    int            skip_left;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic is_noise(input logic [7:0] b);
        return (b == 8'hFA || b == 8'hAA || b == 8'hEE || b == 8'hFE ||
                b == 8'hFC || b == 8'h00 || b == 8'hFF);
    endfunction

    task automatic model_reset();
        m_down = '0; m_pr = '0; m_rel = '0;
        m_code = '0; m_ext = 0; m_brk = 0; m_ev = 0;
        pend_ext = 0; pend_brk = 0; skip_left = 0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] b);
        m_pr = '0; m_rel = '0; m_ev = 0;
        if (v) begin
            if (skip_left > 0) begin
                skip_left--;
            end else if (b == 8'hE0) begin
                pend_ext = 1; pend_brk = 0;
            end else if (b == 8'hE1) begin
                pend_ext = 0; pend_brk = 0; skip_left = 7;
            end else if (b == 8'hF0 && !pend_brk) begin
                pend_brk = 1;
            end else if (!pend_ext && !pend_brk && is_noise(b)) begin
                // discarded
            end else begin
                m_ev = 1; m_code = b; m_ext = pend_ext; m_brk = pend_brk;
                for (int i = 0; i < NK; i++) begin
                    if (code_tab[i] == b && ext_tab[i] == pend_ext) begin
                        if (pend_brk) begin
                            if (m_down[i]) m_rel[i] = 1;
                            m_down[i] = 0;
                        end else begin
                            if (!m_down[i]) m_pr[i] = 1;
                            m_down[i] = 1;
                        end
                    end
                end
                pend_ext = 0; pend_brk = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".key_down"},     16'(key_down),     16'(m_down));
        chk({ph, ".key_pressed"},  16'(key_pressed),  16'(m_pr));
        chk({ph, ".key_released"}, 16'(key_released), 16'(m_rel));
        chk({ph, ".event_valid"},  16'(event_valid),  16'(m_ev));
        chk({ph, ".last_code"},    16'(last_code),    16'(m_code));
        chk({ph, ".last_ext"},     16'(last_ext),     16'(m_ext));
        chk({ph, ".last_break"},   16'(last_break),   16'(m_brk));
    endtask

    task automatic send(input string ph, input logic [7:0] b);
        @(negedge CLOCK_50);
        scan_code  = b;
        scan_valid = 1'b1;
        @(posedge CLOCK_50);
        model_step(1'b1, b);
        #1;
        check_all(ph);
        scan_valid = 1'b0;
    endtask

    task automatic idle(input string ph, input int n);
        repeat (n) begin
            @(negedge CLOCK_50);
            scan_valid = 1'b0;
            @(posedge CLOCK_50);
            model_step(1'b0, 8'h00);
            #1;
            check_all(ph);
        end
    endtask

    task automatic do_reset(input string ph, input logic with_byte);
        @(negedge CLOCK_50);
        resetn     = 1'b0;
        scan_code  = 8'h29;
        scan_valid = with_byte;
        @(posedge CLOCK_50);
        model_reset();
        #1;
        check_all(ph);
        resetn     = 1'b1;
        scan_valid = 1'b0;
    endtask

    logic [7:0] pool [14] = '{8'hE0, 8'hF0, 8'hE1, 8'h29, 8'h5A, 8'h6B, 8'h74,
                              8'hAA, 8'hFA, 8'h00, 8'hFF, 8'hEE, 8'h14, 8'h77};
    logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    initial begin
        int pcnt, ecnt;
        model_reset();

        // reset state
        do_reset("rst", 1'b0);
        chk("rst_down", 16'(key_down), 16'h0);
        chk("rst_ev", 16'(event_valid), 16'h0);

        // space make / break
        send("space_mk", 8'h29);
        chk("space_mk_down", 16'(key_down), 16'h8);
        chk("space_mk_pr", 16'(key_pressed), 16'h8);
        chk("space_mk_code", 16'(last_code), 16'h29);
        idle("space_idle", 1);
        chk("space_pr_gone", 16'(key_pressed), 16'h0);
        send("space_f0", 8'hF0);
        send("space_bk", 8'h29);
        chk("space_bk_rel", 16'(key_released), 16'h8);
        chk("space_bk_lb", 16'(last_break), 16'h1);

        // extended arrows, non-extended alias, extended break
        send("r_e0", 8'hE0); send("r_mk", 8'h74);
        send("l_e0", 8'hE0); send("l_mk", 8'h6B);
        chk("arrows_down", 16'(key_down), 16'h3);
        send("kp6", 8'h74);
        chk("kp6_down", 16'(key_down), 16'h3);
        chk("kp6_ev", 16'(event_valid), 16'h1);
        chk("kp6_ext", 16'(last_ext), 16'h0);
        send("rb_e0", 8'hE0); send("rb_f0", 8'hF0); send("rb", 8'h74);
        chk("rb_down", 16'(key_down), 16'h2);
        chk("rb_rel", 16'(key_released), 16'h1);
        chk("rb_ext", 16'(last_ext), 16'h1);

        // typematic enter, back-to-back bytes
        pcnt = 0; ecnt = 0;
        for (int i = 0; i < 5; i++) begin
            send("typ", 8'h5A);
            pcnt += int'(key_pressed[2]);
            ecnt += int'(event_valid);
        end
        chk("typ_press_cnt", 16'(pcnt), 16'd1);
        chk("typ_ev_cnt", 16'(ecnt), 16'd5);
        chk("typ_down2", 16'(key_down[2]), 16'h1);

        // Pause sequence then space
        ecnt = 0;
        for (int i = 0; i < 8; i++) begin
            send("pause", pause_seq[i]);
            ecnt += int'(event_valid);
        end
        chk("pause_ev_cnt", 16'(ecnt), 16'd0);
        send("post_pause", 8'h29);
        chk("post_pause_down3", 16'(key_down[3]), 16'h1);
        send("sp_rel_f0", 8'hF0); send("sp_rel", 8'h29);

        // noise in IDLE, then break of a key already up
        send("noise_aa", 8'hAA);
        send("noise_fa", 8'hFA);
        send("noise_00", 8'h00);
        chk("noise_ev", 16'(event_valid), 16'h0);
        send("upbrk_f0", 8'hF0); send("upbrk", 8'h29);
        chk("upbrk_ev", 16'(event_valid), 16'h1);
        chk("upbrk_rel", 16'(key_released), 16'h0);

        // reset mid-sequence with coincident byte
        send("mid_f0", 8'hF0);
        do_reset("mid_rst", 1'b1);
        send("mid_mk", 8'h29);
        chk("mid_down3", 16'(key_down[3]), 16'h1);
        chk("mid_pr3", 16'(key_pressed[3]), 16'h1);
        idle("mid_idle", 2);

        // randomized stream
        for (int n = 0; n < 600; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                do_reset("rnd_rst", 1'($urandom_range(0, 1)));
            end else if (r < 12) begin
                idle("rnd_idle", 1);
            end else if (r < 20) begin
                send("rnd_any", 8'($urandom));
            end else begin
                send("rnd", pool[$urandom_range(0, 13)]);
            end
        end
        idle("tail", 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
Parametrised PS/2 set-2 scan-code decoder that tracks held/released state for NUM_KEYS configurable keys at once. It replaces the per-key detectors: one instance serves all game keys. It runs fully synchronous to CLOCK_50 and consumes the byte stream from the keyboard core plus its one-shot read pulse. It decodes E0 (extended) and F0 (break) prefixes and skips the 8-byte Pause sequence. It provides level, make-pulse and break-pulse outputs per key.

Parameters:
NUM_KEYS, 4, number of tracked keys (1..16)
KEY_CODES, {8'h29,8'h5A,8'h6B,8'h74}, packed NUM_KEYS*8 bits; key i code at [8i+7:8i] (default: i=0 right/74, 1 left/6B, 2 enter/5A, 3 space/29)
KEY_EXT, 4'b0011, bit i=1: key i requires E0 prefix; bit i=0: key i must not have E0

Ports:
CLOCK_50  input  1  system clock
resetn  input  1  synchronous active-low reset, sampled on rising CLOCK_50
scan_code  input  8  byte from keyboard core; valid only when scan_valid=1
scan_valid  input  1  one-cycle strobe; a byte is consumed on each cycle it is high
key_down  output  NUM_KEYS  level; bit i=1 while key i is held
key_pressed  output  NUM_KEYS  one-cycle pulse on key i make (up->down only)
key_released  output  NUM_KEYS  one-cycle pulse on key i break (down->up only)
last_code  output  8  code byte of most recent complete event, prefixes stripped
last_ext  output  1  most recent event carried E0
last_break  output  1  most recent event carried F0
event_valid  output  1  one-cycle pulse when last_* update (every complete event, tracked or not)

Behaviour:
- Reset (resetn=0 at a clock edge): all outputs 0, FSM=IDLE, skip counter=0. Reset overrides a simultaneous scan_valid; that byte is dropped.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), SKIP (Pause).
- IDLE: E0->EXT; F0->BRK; E1->SKIP with counter=7. Discard FA, AA, EE, FE, FC, 00, FF with no state change and no event. Any other byte = make event, ext=0, back to IDLE.
- EXT: F0->EXT_BRK. E0 or E1 restarts parsing as if in IDLE. Any other byte = make event with ext=1, then IDLE.
- BRK: any byte except E0/E1 = break event with ext=0, then IDLE. E0/E1 restart parsing as in IDLE.
- EXT_BRK: any byte except E0/E1 = break event with ext=1, then IDLE. E0/E1 restart parsing as in IDLE.
- SKIP: each scan_valid decrements the counter. On the byte that takes it to 0, go to IDLE. No events, no key changes.
- Event timing:
  - Outputs update on the clock edge after the cycle in which the final byte is presented (latency 1).
  - event_valid, last_code, last_ext and last_break update together.
  - last_* hold until the next event.
- Key match: key i matches when code==KEY_CODES[i] and ext==KEY_EXT[i]. Several keys may match if parameters duplicate codes; all matching bits act.
- Make on key i:
  - key_down[i]<=1.
  - key_pressed[i] pulses only if key_down[i] was 0, so typematic repeat makes give no pulse.
- Break on key i:
  - key_down[i]<=0.
  - key_released[i] pulses only if key_down[i] was 1.
- Pulses are 1 cycle wide; all pulse outputs are 0 on cycles with no event.
- Independent keys are fully concurrent: holding k0 and pressing k1 sets both bits.
- Reset mid-sequence (e.g. after F0): FSM returns to IDLE. The next byte is parsed as a fresh make.
- scan_valid on consecutive cycles is legal; one byte is consumed per cycle.

Test Plan:
- Reset, then space make 29 -> key_down=4'b1000, key_pressed=4'b1000 for 1 cycle, event_valid=1, last_code=29, last_ext=0, last_break=0; then F0 29 -> key_down=0, key_released=4'b1000 pulse, last_break=1.
- E0 74 (right) then E0 6B (left) -> key_down=4'b0011; bytes 74 without E0 change nothing, event_valid=1 with last_ext=0; E0 F0 74 -> key_down=4'b0010, key_released=4'b0001, last_ext=1, last_break=1.
- Typematic: 5A repeated 5 times -> key_pressed[2] pulses once, key_down[2] stays 1, event_valid pulses 5 times.
- Pause sequence E1 14 77 E1 F0 14 F0 77 followed by 29 -> no events during the 8 bytes; 29 then sets key_down[3].
- Noise/ack bytes AA, FA, 00 in IDLE -> no event_valid, state unchanged; break F0 29 with key already up -> event_valid=1, no key_released pulse.
- Send F0, assert resetn=0 for 1 cycle, then 29 -> treated as make: key_down[3]=1, key_pressed[3] pulses; scan_valid coincident with resetn=0 is ignored.
